// File: rtl/n64_pkg.sv
// Shared types and timing constants for the N64 controller poll scheduler.
package n64_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_BIT,
        ST_TX_STOP,
        ST_RX_WAIT,
        ST_RX_SAMPLE,
        ST_DONE,
        ST_HOLDOFF
    } state_t;

    localparam logic [7:0] N64_CMD_POLL  = 8'h01;
    localparam int         N64_CMD_BITS  = 8;
    localparam int         N64_RESP_BITS = 32;
    localparam int         N64_MAX_RETRY = 2;

    // Host bit phases in microseconds: '0' is long-low, '1' is short-low.
    localparam int BIT_ZERO_LOW_US  = 3;
    localparam int BIT_ZERO_HIGH_US = 1;
    localparam int BIT_ONE_LOW_US   = 1;
    localparam int BIT_ONE_HIGH_US  = 3;
    localparam int STOP_LOW_US      = 1;
    localparam int STOP_HIGH_US     = 2;
    localparam int SAMPLE_US        = 2;

endpackage

// File: rtl/n64_din_sync.sv
// Two-flop synchroniser for the controller data line with a falling-edge pulse.
module n64_din_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic din_sync,
    output logic fall
);

    logic [2:0] sync_q;

    // Reset to the idle-high line level so no false edge appears after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign din_sync = sync_q[1];
    assign fall     = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/n64_poll_scheduler.sv
// N64 controller poll sequencer: sends 0x01, deserialises the 32-bit reply, detects timeouts.
// Optional macro N64_RETRY_EN re-issues a timed-out poll up to two more times.
module n64_poll_scheduler
    import n64_pkg::*;
#(
    parameter int CLK_PER_US     = 100,
    parameter int POLL_PERIOD_US = 16000,
    parameter int TIMEOUT_US     = 12,
    parameter int HOLDOFF_US     = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        poll_req,
    input  logic        Din,
    output logic        Dout,
    output logic        busy,
    output logic [31:0] buttons,
    output logic        buttons_valid,
    output logic        timeout_err
);

    localparam logic [15:0] BIT_CYC      = 16'((BIT_ONE_LOW_US + BIT_ONE_HIGH_US) * CLK_PER_US);
    localparam logic [15:0] ONE_LOW_CYC  = 16'(BIT_ONE_LOW_US * CLK_PER_US);
    localparam logic [15:0] ZERO_LOW_CYC = 16'(BIT_ZERO_LOW_US * CLK_PER_US);
    localparam logic [15:0] STOP_LOW_CYC = 16'(STOP_LOW_US * CLK_PER_US);
    localparam logic [15:0] STOP_CYC     = 16'((STOP_LOW_US + STOP_HIGH_US) * CLK_PER_US);
    localparam logic [15:0] SAMPLE_CYC   = 16'(SAMPLE_US * CLK_PER_US);
    localparam logic [15:0] TIMEOUT_CYC  = 16'(TIMEOUT_US * CLK_PER_US);
    localparam logic [15:0] HOLDOFF_CYC  = 16'(HOLDOFF_US * CLK_PER_US);
    localparam logic [23:0] PERIOD_CYC   = 24'(POLL_PERIOD_US * CLK_PER_US);

    state_t      state, state_next;
    logic [15:0] bit_timer, timer_next;
    logic [23:0] period_timer;
    logic [5:0]  bit_idx, idx_next;
    logic [31:0] shift_q, shift_next;
    logic        pending;
    logic        din_sync, din_fall;
    logic        period_hit, start, done, fail, dout_c;
    logic [15:0] tx_low_cyc;

`ifdef N64_RETRY_EN
    logic [1:0] attempt, attempt_next;
    logic       retry_q, retry_next;
`endif

    n64_din_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .din      (Din),
        .din_sync (din_sync),
        .fall     (din_fall)
    );

    assign period_hit = enable && (period_timer >= PERIOD_CYC - 24'd1);
    assign tx_low_cyc = N64_CMD_POLL[~bit_idx[2:0]] ? ONE_LOW_CYC : ZERO_LOW_CYC;

    always_comb begin
        state_next = state;
        timer_next = bit_timer + 16'd1;
        idx_next   = bit_idx;
        shift_next = shift_q;
        dout_c     = 1'b1;
        start      = 1'b0;
        done       = 1'b0;
        fail       = 1'b0;
`ifdef N64_RETRY_EN
        attempt_next = attempt;
        retry_next   = retry_q;
`endif
        case (state)
            ST_IDLE: begin
                timer_next = 16'd0;
                if (poll_req || pending || period_hit) begin
                    start      = 1'b1;
                    state_next = ST_TX_BIT;
                    idx_next   = 6'd0;
`ifdef N64_RETRY_EN
                    attempt_next = 2'd0;
`endif
                end
            end
            ST_TX_BIT: begin
                dout_c = (bit_timer >= tx_low_cyc);
                if (bit_timer == BIT_CYC - 16'd1) begin
                    timer_next = 16'd0;
                    if (bit_idx == 6'(N64_CMD_BITS - 1)) begin
                        state_next = ST_TX_STOP;
                        idx_next   = 6'd0;
                    end else begin
                        idx_next = bit_idx + 6'd1;
                    end
                end
            end
            ST_TX_STOP: begin
                dout_c = (bit_timer >= STOP_LOW_CYC);
                if (bit_timer == STOP_CYC - 16'd1) begin
                    timer_next = 16'd0;
                    state_next = ST_RX_WAIT;
                end
            end
            // The timer keeps running from the last edge through RX_SAMPLE.
            ST_RX_WAIT: begin
                if (din_fall) begin
                    timer_next = 16'd0;
                    state_next = ST_RX_SAMPLE;
                end else if (bit_timer >= TIMEOUT_CYC - 16'd1) begin
                    timer_next = 16'd0;
                    state_next = ST_HOLDOFF;
`ifdef N64_RETRY_EN
                    if (attempt == 2'(N64_MAX_RETRY)) fail = 1'b1;
                    else retry_next = 1'b1;
`else
                    fail = 1'b1;
`endif
                end
            end
            ST_RX_SAMPLE: begin
                if (bit_timer == SAMPLE_CYC - 16'd1) begin
                    shift_next = {shift_q[30:0], din_sync};
                    idx_next   = bit_idx + 6'd1;
                    if (bit_idx == 6'(N64_RESP_BITS - 1)) begin
                        timer_next = 16'd0;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_RX_WAIT;
                    end
                end
            end
            ST_DONE: begin
                timer_next = 16'd0;
                done       = 1'b1;
                state_next = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (bit_timer == HOLDOFF_CYC - 16'd1) begin
                    timer_next = 16'd0;
                    state_next = ST_IDLE;
`ifdef N64_RETRY_EN
                    if (retry_q) begin
                        state_next   = ST_TX_BIT;
                        idx_next     = 6'd0;
                        retry_next   = 1'b0;
                        attempt_next = attempt + 2'd1;
                    end
`endif
                end
            end
            default: begin
                timer_next = 16'd0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            bit_timer     <= 16'd0;
            period_timer  <= 24'd0;
            bit_idx       <= 6'd0;
            shift_q       <= 32'd0;
            pending       <= 1'b0;
            buttons       <= 32'd0;
            buttons_valid <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= state_next;
            bit_timer     <= timer_next;
            bit_idx       <= idx_next;
            shift_q       <= shift_next;
            buttons_valid <= done;
            if (done) begin
                buttons     <= shift_q;
                timeout_err <= 1'b0;
            end else if (fail) begin
                timeout_err <= 1'b1;
            end
            if (start) pending <= 1'b0;
            else if (poll_req && state != ST_IDLE) pending <= 1'b1;
            if (!enable || start) period_timer <= 24'd0;
            else if (!period_hit) period_timer <= period_timer + 24'd1;
        end
    end

`ifdef N64_RETRY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            attempt <= 2'd0;
            retry_q <= 1'b0;
        end else begin
            attempt <= attempt_next;
            retry_q <= retry_next;
        end
    end
`endif

    assign Dout = dout_c;
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// Directed bench for n64_poll_scheduler with an open-drain controller model on the data line.
module tb_n64_poll_scheduler;

    localparam int CPU      = 10;
    localparam int PERIOD   = 400 * CPU;
    localparam int TO_DELAY = 2 * CPU + 12 * CPU;   // stop rise -> stop end -> timeout

    logic        clk = 1'b0;
    logic        reset, enable, poll_req, ctrl_low;
    logic        din_line, Dout, busy, buttons_valid, timeout_err;
    logic [31:0] buttons;

    int n_vec = 0, n_miss = 0;
    int cyc = 0, low_len = 0, rise_cnt = 0, last_rise = 0;
    int busy_rises = 0, last_busy_rise = 0, last_busy_fall = 0, busy_gap = 0;
    int valid_cycles = 0, err_rise_cyc = 0;
    logic       dout_q = 1'b1, busy_q = 1'b0, err_q = 1'b0;
    logic [8:0] cmd_sr = 9'd0;
    int base, v0, t1;

    always #5 clk = ~clk;

    assign din_line = Dout & ~ctrl_low;

    n64_poll_scheduler #(
        .CLK_PER_US     (CPU),
        .POLL_PERIOD_US (400),
        .TIMEOUT_US     (12),
        .HOLDOFF_US     (100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .poll_req      (poll_req),
        .Din           (din_line),
        .Dout          (Dout),
        .busy          (busy),
        .buttons       (buttons),
        .buttons_valid (buttons_valid),
        .timeout_err   (timeout_err)
    );

    // Line monitor: decodes host bits by low width and timestamps events.
    always @(negedge clk) begin
        cyc++;
        if (!Dout) begin
            low_len++;
        end else begin
            if (!dout_q) begin
                rise_cnt++;
                last_rise = cyc;
                cmd_sr = {cmd_sr[7:0], (low_len < 2 * CPU)};
            end
            low_len = 0;
        end
        if (busy && !busy_q) begin
            busy_rises++;
            busy_gap = cyc - last_busy_fall;
            last_busy_rise = cyc;
        end
        if (!busy && busy_q) last_busy_fall = cyc;
        if (buttons_valid) valid_cycles++;
        if (timeout_err && !err_q) err_rise_cyc = cyc;
        dout_q = Dout;
        busy_q = busy;
        err_q  = timeout_err;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic pulse_req();
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        @(negedge clk);
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_vec(tag, {31'd0, busy}, 32'd0);
    endtask

    // Controller model: waits for the host stop bit, then sends nbits of d MSB first.
    task automatic respond(input int rises, input logic [31:0] d, input int jit, input int nbits);
        int n = 0;
        int lo, hi;
        while (rise_cnt < rises && n < 8000) begin
            @(negedge clk);
            n++;
        end
        if (rise_cnt < rises) check_vec("resp_wait", rise_cnt, rises);
        repeat (25) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            lo = (d[31 - i] ? CPU : 3 * CPU) + ((i % 2 == 1) ? jit : -jit);
            hi = (d[31 - i] ? 3 * CPU : CPU) + ((i % 3 == 0) ? jit : -jit);
            ctrl_low = 1'b1;
            repeat (lo) @(negedge clk);
            ctrl_low = 1'b0;
            repeat (hi) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; poll_req = 1'b0; ctrl_low = 1'b0;
        repeat (4) @(negedge clk);
        check_vec("rst_dout",  {31'd0, Dout}, 32'd1);
        check_vec("rst_busy",  {31'd0, busy}, 32'd0);
        check_vec("rst_btn",   buttons, 32'd0);
        check_vec("rst_valid", {31'd0, buttons_valid}, 32'd0);
        check_vec("rst_err",   {31'd0, timeout_err}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset in the middle of a response discards it.
        base = rise_cnt;
        pulse_req();
        check_vec("start_lat", {31'd0, Dout}, 32'd0);
        respond(base + 9, 32'hA5A5_A5A5, 0, 17);
        reset = 1'b0;
        @(negedge clk);
        check_vec("mid_rst_dout", {31'd0, Dout}, 32'd1);
        check_vec("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_vec("mid_rst_btn",  buttons, 32'd0);
        reset = 1'b1;
        repeat (300) @(negedge clk);
        check_vec("mid_rst_valid", valid_cycles, 0);

        // Clean poll answered with 0x80000000.
        base = rise_cnt;
        v0 = valid_cycles;
        pulse_req();
        respond(base + 9, 32'h8000_0000, 0, 32);
        wait_idle("idle_a", 3000);
        check_vec("cmd_0x01",  {23'd0, cmd_sr}, 32'h003);
        check_vec("btn_a",     buttons, 32'h8000_0000);
        check_vec("valid_len", valid_cycles - v0, 1);
        check_vec("err_a",     {31'd0, timeout_err}, 32'd0);

        // No controller: timeout.
        base = rise_cnt;
        v0 = valid_cycles;
        pulse_req();
        wait_idle("idle_to", 8000);
        check_vec("to_err",   {31'd0, timeout_err}, 32'd1);
        check_vec("to_btn",   buttons, 32'h8000_0000);
        check_vec("to_delay", err_rise_cyc - last_rise, TO_DELAY);
        check_vec("to_valid", valid_cycles - v0, 0);
`ifdef N64_RETRY_EN
        check_vec("to_bursts", rise_cnt - base, 27);
`else
        check_vec("to_bursts", rise_cnt - base, 9);
`endif

        // Recovery with jittered controller bits.
        base = rise_cnt;
        pulse_req();
        respond(base + 9, 32'hFFFF_0000, 5, 32);
        wait_idle("idle_j", 3000);
        check_vec("jit_btn", buttons, 32'hFFFF_0000);
        check_vec("jit_err", {31'd0, timeout_err}, 32'd0);

        // Requests while busy: one held, the second dropped.
        base = rise_cnt;
        v0 = busy_rises;
        pulse_req();
        repeat (50) @(negedge clk);
        pulse_req();
        repeat (2) @(negedge clk);
        pulse_req();
        respond(base + 9, 32'h1234_5678, 0, 32);
        check_vec("pend_btn1", buttons, 32'h1234_5678);
        respond(base + 18, 32'h0F0F_00F0, 0, 32);
        wait_idle("idle_p", 3000);
        repeat (300) @(negedge clk);
        check_vec("pend_starts", busy_rises - v0, 2);
        check_vec("pend_gap",    busy_gap, 1);
        check_vec("pend_btn2",   buttons, 32'h0F0F_00F0);

        // Auto-poll period.
        base = rise_cnt;
        enable = 1'b1;
        respond(base + 9, 32'h0000_00FF, 0, 32);
        t1 = last_busy_rise;
        respond(base + 18, 32'h00C3_0001, 0, 32);
        check_vec("period", last_busy_rise - t1, PERIOD);
        enable = 1'b0;
        wait_idle("idle_e", 3000);
        check_vec("per_btn", buttons, 32'h00C3_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
